countdown_timer: RTL and testbench



---
 rtl/countdown_timer_if.sv | 26 ++
 rtl/countdown_timer.sv | 117 +++++++++++
 tb/tb_countdown_timer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/countdown_timer_if.sv
// Load handshake and status bundle for countdown_timer.
// The master side issues loads and run controls; the slave side is the timer.
interface countdown_timer_if #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
);
    logic                  i_load_valid;
    logic                  o_load_ready;
    logic [WIDTH-1:0]      i_load_value;
    logic [PRESCALE_W-1:0] i_prescale;
    logic                  i_en;
    logic                  i_abort;
    logic [WIDTH-1:0]      o_count;
    logic                  o_busy;
    logic                  o_done;

    modport master (
        output i_load_valid, i_load_value, i_prescale, i_en, i_abort,
        input  o_load_ready, o_count, o_busy, o_done
    );

    modport slave (
        input  i_load_valid, i_load_value, i_prescale, i_en, i_abort,
        output o_load_ready, o_count, o_busy, o_done
    );
endinterface

// File: rtl/countdown_timer.sv
// Loadable prescaled down-counter that pulses o_done on expiry.
// Define COUNTDOWN_AUTO_RELOAD_EN to make DONE reload and restart instead of returning to IDLE.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for a load; the only state where o_load_ready is high
// RUN    | counting down at the latched prescaled rate
// DONE   | single expiry cycle; o_done is high
module countdown_timer #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    countdown_timer_if.slave  tmr
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [WIDTH-1:0]      CNT_ONE = WIDTH'(1);
    localparam logic [PRESCALE_W-1:0] PRE_ONE = PRESCALE_W'(1);

    logic [1:0]            state_q, state_d;
    logic [WIDTH-1:0]      count_q, count_d;
    logic [PRESCALE_W-1:0] pre_q, pre_d;
    logic [PRESCALE_W-1:0] pre_ld_q, pre_ld_d;
    logic [WIDTH-1:0]      rl_q, rl_d;
    logic                  done_q, done_d;
    logic                  load_ready;
    logic                  load_accept;

    assign load_ready  = (state_q == S_IDLE);
    assign load_accept = tmr.i_load_valid && load_ready;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        pre_d    = pre_q;
        pre_ld_d = pre_ld_q;
        rl_d     = rl_q;

        case (state_q)
            S_IDLE: begin
                if (load_accept) begin
                    count_d  = tmr.i_load_value;
                    rl_d     = tmr.i_load_value;
                    pre_d    = tmr.i_prescale;
                    pre_ld_d = tmr.i_prescale;
                    state_d  = (tmr.i_load_value == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (tmr.i_abort) begin
                    state_d = S_IDLE;
                    count_d = '0;
                end else if (tmr.i_en) begin
                    if (pre_q != '0) begin
                        pre_d = pre_q - PRE_ONE;
                    end else begin
                        pre_d = pre_ld_q;
                        // count is never 0 in RUN, but guard so it can never wrap
                        if (count_q != '0) begin
                            count_d = count_q - CNT_ONE;
                        end
                        if (count_q <= CNT_ONE) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                if (!tmr.i_abort && (rl_q != '0)) begin
                    state_d = S_RUN;
                    count_d = rl_q;
                    pre_d   = pre_ld_q;
                end else begin
                    state_d = S_IDLE;
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase

        // registered so o_done is a clean flop output aligned with DONE
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            pre_q    <= '0;
            pre_ld_q <= '0;
            rl_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            pre_q    <= pre_d;
            pre_ld_q <= pre_ld_d;
            rl_q     <= rl_d;
            done_q   <= done_d;
        end
    end

    assign tmr.o_load_ready = load_ready;
    assign tmr.o_count      = count_q;
    assign tmr.o_busy       = (state_q != S_IDLE);
    assign tmr.o_done       = done_q;
endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed test-plan scenarios followed by
// random traffic, all checked every cycle against a remaining-cycles reference model.
module tb_countdown_timer;
    localparam int WIDTH      = 8;
    localparam int PRESCALE_W = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    countdown_timer_if #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) bus ();

    countdown_timer #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .tmr     (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: a run needs N*(P+1) enabled cycles; the visible count is
    // the number of whole prescale periods still outstanding (rounded up).
    int m_phase;   // 0 idle, 1 running, 2 expiry cycle
    int m_left;
    int m_per;
    int m_n;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic v, input int val, input int p,
                              input logic en, input logic ab, input logic r);
        if (r) begin
            m_phase = 0;
            m_left  = 0;
            m_n     = 0;
            m_per   = 1;
        end else begin
            case (m_phase)
                0: if (v) begin
                    m_n     = val;
                    m_per   = p + 1;
                    m_left  = val * m_per;
                    m_phase = (val == 0) ? 2 : 1;
                end
                1: if (ab) begin
                    m_phase = 0;
                end else if (en) begin
                    m_left--;
                    if (m_left == 0) m_phase = 2;
                end
                default: begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    if (!ab && m_n != 0) begin
                        m_phase = 1;
                        m_left  = m_n * m_per;
                    end else begin
                        m_phase = 0;
                    end
`else
                    m_phase = 0;
`endif
                end
            endcase
        end
    endtask

    function automatic int model_count();
        if (m_phase == 1) return (m_left + m_per - 1) / m_per;
        return 0;
    endfunction

    task automatic cyc(input logic v, input int val, input int p,
                       input logic en, input logic ab, input logic r);
        bus.i_load_valid = v;
        bus.i_load_value = val[WIDTH-1:0];
        bus.i_prescale   = p[PRESCALE_W-1:0];
        bus.i_en         = en;
        bus.i_abort      = ab;
        rst              = r;
        @(posedge clk);
        model_step(v, val, p, en, ab, r);
        @(negedge clk);
        check_eq("count", int'(bus.o_count), model_count());
        check_eq("busy",  int'(bus.o_busy),  int'(m_phase != 0));
        check_eq("done",  int'(bus.o_done),  int'(m_phase == 2));
        check_eq("ready", int'(bus.o_load_ready), int'(m_phase == 0));
    endtask

    task automatic idle_run(input int cycles);
        for (int i = 0; i < cycles; i++) cyc(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_phase  = 0;
        m_left   = 0;
        m_per    = 1;
        m_n      = 0;
        bus.i_load_valid = 1'b0;
        bus.i_load_value = '0;
        bus.i_prescale   = '0;
        bus.i_en         = 1'b0;
        bus.i_abort      = 1'b0;
        rst              = 1'b1;

        cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 9, 3, 1'b1, 1'b1, 1'b1);
        check_eq("rst_count", int'(bus.o_count), 0);
        check_eq("rst_ready", int'(bus.o_load_ready), 1);
        check_eq("rst_busy",  int'(bus.o_busy), 0);

        // N=3, P=0: count 3,2,1,0 with done on the 0 cycle
        cyc(1'b1, 3, 0, 1'b1, 1'b0, 1'b0);
        check_eq("s1_cnt3", int'(bus.o_count), 3);
        cyc(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
        check_eq("s1_cnt2", int'(bus.o_count), 2);
        cyc(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
        check_eq("s1_cnt1", int'(bus.o_count), 1);
        cyc(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
        check_eq("s1_cnt0", int'(bus.o_count), 0);
        check_eq("s1_done", int'(bus.o_done), 1);
        cyc(1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
        idle_run(2);

        // N=2, P=2
        cyc(1'b1, 2, 2, 1'b1, 1'b0, 1'b0);
        idle_run(8);

        // N=4, P=0 with a 5-cycle enable gap after the first decrement
        cyc(1'b1, 4, 0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        idle_run(4);
        cyc(1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
        idle_run(1);

        // N=10 aborted at cycle 4, then a fresh load
        cyc(1'b1, 10, 0, 1'b1, 1'b0, 1'b0);
        idle_run(3);
        cyc(1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
        check_eq("abort_cnt",  int'(bus.o_count), 0);
        check_eq("abort_busy", int'(bus.o_busy), 0);
        cyc(1'b1, 5, 1, 1'b1, 1'b0, 1'b0);
        check_eq("reload_cnt", int'(bus.o_count), 5);
        idle_run(12);
        cyc(1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
        idle_run(1);

        // zero load, then reset in the middle of a long run
        cyc(1'b1, 0, 0, 1'b1, 1'b0, 1'b0);
        check_eq("zero_done", int'(bus.o_done), 1);
        cyc(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
        idle_run(1);
        cyc(1'b1, 200, 1, 1'b1, 1'b0, 1'b0);
        idle_run(20);
        cyc(1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
        check_eq("mrst_count", int'(bus.o_count), 0);
        check_eq("mrst_busy",  int'(bus.o_busy), 0);
        check_eq("mrst_ready", int'(bus.o_load_ready), 1);

        // N=2, P=0 left free-running (loops when auto-reload is built in), then aborted
        cyc(1'b1, 2, 0, 1'b1, 1'b0, 1'b0);
        idle_run(12);
        cyc(1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
        idle_run(3);

        for (int i = 0; i < 3000; i++) begin
            logic v, en, ab, r;
            int   val, p;
            v   = ($urandom_range(0, 1) == 1);
            val = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 6));
            p   = int'($urandom_range(0, 3));
            en  = ($urandom_range(0, 9) < 8);
            ab  = ($urandom_range(0, 39) == 0);
            r   = ($urandom_range(0, 149) == 0);
            cyc(v, val, p, en, ab, r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
